// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2, one bit per cycle,
// valid/ready on both sides, flushable at any point.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            in_flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;

  logic [XLEN-1:0]   b_mag;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN:0]     rem;
  logic              is_div, is_rem, sel_hi, neg;

  logic              a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]   a_abs, b_abs, spec_res;

  logic [XLEN:0]     psum;
  logic [2*XLEN-1:0] prod_nx, prod_fin;
  logic [XLEN+1:0]   trial;
  logic [XLEN:0]     rem_nx;
  logic [XLEN-1:0]   quo_nx, div_raw, fin;

  function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg_w(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Operand decode on the accept edge: magnitudes, sign flags, special cases
  always_comb begin
    a_sgn    = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_sgn    = funct3[2] ? ~funct3[0] : ~funct3[1];
    a_neg    = a_sgn & op_a[XLEN-1];
    b_neg    = b_sgn & op_b[XLEN-1];
    a_abs    = cneg(op_a, a_neg);
    b_abs    = cneg(op_b, b_neg);
    div_zero = funct3[2] & (op_b == '0);
    div_ovf  = funct3[2] & ~funct3[0] & (op_a == INT_MIN) & (op_b == '1);
    if (div_zero) spec_res = funct3[1] ? op_a : '1;
    else          spec_res = funct3[1] ? '0 : op_a;
  end

  // One iteration: shift-add on the product, restoring subtract on the quotient
  always_comb begin
    psum     = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, (prod[0] ? b_mag : {XLEN{1'b0}})};
    prod_nx  = {psum, prod[XLEN-1:1]};
    trial    = {rem, quo[XLEN-1]} - {2'b00, b_mag};
    if (trial[XLEN+1]) begin
      rem_nx = {rem[XLEN-1:0], quo[XLEN-1]};
      quo_nx = {quo[XLEN-2:0], 1'b0};
    end else begin
      rem_nx = trial[XLEN:0];
      quo_nx = {quo[XLEN-2:0], 1'b1};
    end
    // Sign must be applied to the full product before picking the high half
    prod_fin = cneg_w(prod_nx, neg);
    div_raw  = is_rem ? rem_nx[XLEN-1:0] : quo_nx;
    if (is_div)      fin = cneg(div_raw, neg);
    else if (sel_hi) fin = prod_fin[2*XLEN-1:XLEN];
    else             fin = prod_fin[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      result <= '0;
    end else if (in_flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          cnt <= '0;
          if (div_zero || div_ovf) begin
            state  <= S_DONE;
            result <= spec_res;
          end else begin
            state <= S_CALC;
          end
        end
        S_CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state  <= S_DONE;
            result <= fin;
          end
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Working registers carry no reset; the state machine qualifies them
  always_ff @(posedge clk) begin
    if (state == S_IDLE && in_valid && !in_flush) begin
      b_mag  <= b_abs;
      prod   <= {{XLEN{1'b0}}, a_abs};
      quo    <= a_abs;
      rem    <= '0;
      is_div <= funct3[2];
      is_rem <= funct3[2] & funct3[1];
      sel_hi <= (funct3[1:0] != 2'b00);
      neg    <= (funct3[2] & funct3[1]) ? a_neg : (a_neg ^ b_neg);
    end else if (state == S_CALC) begin
      prod <= prod_nx;
      quo  <= quo_nx;
      rem  <= rem_nx;
    end
  end

endmodule
